// File: rtl/scr1_sha_sched_if.sv
// rtl/scr1_sha_sched_if.sv - requester/engine handshake bundle for the SHA-256 block scheduler
//
// Signals (direction as seen by the scheduler, modport slave):
//   req       in   2          per-requester job request, level, held until job_done
//   nblk      in   2xNBLK_W   per-requester block count, sampled at grant
//   gnt       out  2          one-hot grant, held for the whole job
//   blk_vld   in   2          requester has its next 16-word block staged
//   blk_ack   out  2          pulse: block consumed, requester may restage
//   job_done  out  2          pulse: job finished normally
//   job_err   out  2          pulse: job aborted
//   eng_init  out  1          pulse: engine reloads the SHA-256 IV
//   eng_go    out  1          pulse: engine starts one block
//   eng_done  in   1          engine block-complete, level
//   eng_sel   out  1          which requester's data feeds the engine
//   busy      out  1          scheduler is not idle
// modport master is the requester/engine side of the same bundle.

interface scr1_sha_sched_if #(
    parameter int NBLK_W = 8
);
    logic [1:0]             req;
    logic [1:0][NBLK_W-1:0] nblk;
    logic [1:0]             gnt;
    logic [1:0]             blk_vld;
    logic [1:0]             blk_ack;
    logic [1:0]             job_done;
    logic [1:0]             job_err;
    logic                   eng_init;
    logic                   eng_go;
    logic                   eng_done;
    logic                   eng_sel;
    logic                   busy;

    modport master (
        output req, nblk, blk_vld, eng_done,
        input  gnt, blk_ack, job_done, job_err, eng_init, eng_go, eng_sel, busy
    );

    modport slave (
        input  req, nblk, blk_vld, eng_done,
        output gnt, blk_ack, job_done, job_err, eng_init, eng_go, eng_sel, busy
    );
endinterface

// File: rtl/scr1_sha_sched.sv
// rtl/scr1_sha_sched.sv - two-requester job scheduler for a shared SHA-256 block engine
//
// Grants one of two requesters by round-robin, initialises the engine once per
// job, then feeds it the requester's blocks one at a time until the job's block
// count is exhausted or the requester withdraws its request.
//
// Ports:
//   clk   in   single clock, rising edge
//   rst   in   synchronous, active-high reset
//   bus   scr1_sha_sched_if.slave - requester and engine handshake (see interface)
//
// Parameters:
//   NBLK_W    width of the per-job block count
//   WDOG_CYC  engine-done timeout in WAIT cycles (watchdog build only)
//
// Build option:
//   SCR1_SHA_SCHED_WDOG_EN - when defined, a WAIT that lasts WDOG_CYC cycles
//   without eng_done aborts the job and re-initialises the engine.

module scr1_sha_sched #(
    parameter int NBLK_W   = 8,
    parameter int WDOG_CYC = 64
) (
    input  logic            clk,
    input  logic            rst,
    scr1_sha_sched_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_INIT, S_LOAD, S_GO, S_WAIT, S_NEXT
    } state_t;

    state_t            state_q;
    logic [1:0]        gnt_q, blk_ack_q, job_done_q, job_err_q;
    logic              eng_init_q, eng_go_q, eng_sel_q, busy_q;
    logic              rr_q;          // requester that has priority on a tie
    logic [NBLK_W-1:0] cnt_q;         // blocks still to run in the current job

    logic              win_d;
    logic [NBLK_W-1:0] cnt_d;
    logic              abort_d;

`ifdef SCR1_SHA_SCHED_WDOG_EN
    localparam int WD_W = $clog2(WDOG_CYC + 1);
    logic [WD_W-1:0] wdog_q;
`else
    if (WDOG_CYC < 0) begin : g_wdog_absent
    end
`endif

    always_comb begin
        win_d   = bus.req[rr_q] ? rr_q : ~rr_q;
        cnt_d   = (bus.nblk[win_d] == '0) ? NBLK_W'(1) : bus.nblk[win_d];
        // Once the final NEXT has issued job_done the job is complete, so a
        // request dropped in that cycle must not also raise job_err.
        abort_d = (state_q != S_IDLE) && !bus.req[eng_sel_q] &&
                  !((state_q == S_NEXT) && (cnt_q == '0));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            gnt_q      <= '0;
            blk_ack_q  <= '0;
            job_done_q <= '0;
            job_err_q  <= '0;
            eng_init_q <= 1'b0;
            eng_go_q   <= 1'b0;
            eng_sel_q  <= 1'b0;
            busy_q     <= 1'b0;
            rr_q       <= 1'b0;
            cnt_q      <= '0;
`ifdef SCR1_SHA_SCHED_WDOG_EN
            wdog_q     <= '0;
`endif
        end else begin
            blk_ack_q  <= '0;
            job_done_q <= '0;
            job_err_q  <= '0;
            eng_init_q <= 1'b0;
            eng_go_q   <= 1'b0;

            if (abort_d) begin
                job_err_q <= gnt_q;
                gnt_q     <= '0;
                busy_q    <= 1'b0;
                state_q   <= S_IDLE;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (|bus.req) begin
                            gnt_q      <= 2'(2'b01 << win_d);
                            eng_sel_q  <= win_d;
                            rr_q       <= ~win_d;
                            cnt_q      <= cnt_d;
                            eng_init_q <= 1'b1;
                            busy_q     <= 1'b1;
                            state_q    <= S_INIT;
                        end
                    end
                    S_INIT: state_q <= S_LOAD;
                    S_LOAD: begin
                        if (bus.blk_vld[eng_sel_q]) begin
                            state_q <= S_GO;
                        end
                    end
                    S_GO: begin
                        // A done still high from the previous block would be
                        // mistaken for this block's completion in WAIT.
                        if (!bus.eng_done) begin
                            eng_go_q <= 1'b1;
                            state_q  <= S_WAIT;
`ifdef SCR1_SHA_SCHED_WDOG_EN
                            wdog_q   <= '0;
`endif
                        end
                    end
                    S_WAIT: begin
                        if (bus.eng_done) begin
                            blk_ack_q <= gnt_q;
                            cnt_q     <= cnt_q - NBLK_W'(1);
                            if (cnt_q == NBLK_W'(1)) begin
                                job_done_q <= gnt_q;
                            end
                            state_q <= S_NEXT;
                        end
`ifdef SCR1_SHA_SCHED_WDOG_EN
                        else if (wdog_q == WD_W'(WDOG_CYC - 1)) begin
                            // Engine state is unknown after a hang; reload the IV.
                            job_err_q  <= gnt_q;
                            eng_init_q <= 1'b1;
                            gnt_q      <= '0;
                            busy_q     <= 1'b0;
                            state_q    <= S_IDLE;
                        end else begin
                            wdog_q <= wdog_q + WD_W'(1);
                        end
`endif
                    end
                    S_NEXT: begin
                        if (cnt_q == '0) begin
                            gnt_q   <= '0;
                            busy_q  <= 1'b0;
                            state_q <= S_IDLE;
                        end else begin
                            state_q <= S_LOAD;
                        end
                    end
                    default: begin
                        gnt_q   <= '0;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.gnt      = gnt_q;
    assign bus.blk_ack  = blk_ack_q;
    assign bus.job_done = job_done_q;
    assign bus.job_err  = job_err_q;
    assign bus.eng_init = eng_init_q;
    assign bus.eng_go   = eng_go_q;
    assign bus.eng_sel  = eng_sel_q;
    assign bus.busy     = busy_q;
endmodule

// File: tb/tb_scr1_sha_sched.sv
// tb/tb_scr1_sha_sched.sv - self-checking bench for scr1_sha_sched
module tb_scr1_sha_sched;
    localparam int NBLK_W = 8;
    localparam int WDOG   = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    scr1_sha_sched_if #(.NBLK_W(NBLK_W)) bus ();

    scr1_sha_sched #(.NBLK_W(NBLK_W), .WDOG_CYC(WDOG)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_vec = 0;
    int n_bad = 0;
    int c_init, c_go;
    int c_ack[2], c_done[2], c_err[2];
    int eng_lat = 1;
    int eng_cd  = 0;
    int stage_gap = 0;
    int vld_cd[2];
    bit vld_auto = 1'b1;
    int rr_pref = 0;

    typedef struct {
        logic [1:0] req;
        int nb0;
        int nb1;
        int lat;
        int gap;
        int exp_w;
        int exp_blk;
    } vec_t;
    vec_t tbl[6];

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int outs();
        return int'({bus.gnt, bus.blk_ack, bus.job_done, bus.job_err,
                     bus.eng_init, bus.eng_go, bus.eng_sel, bus.busy});
    endfunction

    function automatic int pulses();
        return int'({bus.blk_ack, bus.job_done, bus.job_err, bus.eng_init, bus.eng_go});
    endfunction

    function automatic int pick(input logic [1:0] r, input int pref);
        return r[pref] ? pref : 1 - pref;
    endfunction

    task automatic clr();
        c_init = 0; c_go = 0;
        for (int i = 0; i < 2; i++) begin
            c_ack[i] = 0; c_done[i] = 0; c_err[i] = 0;
        end
    endtask

    // One clock: sample outputs on the falling edge, then update the engine
    // and requester models and drive the inputs for the next rising edge.
    task automatic step();
        @(negedge clk);
        c_init += int'(bus.eng_init);
        c_go   += int'(bus.eng_go);
        for (int i = 0; i < 2; i++) begin
            c_ack[i]  += int'(bus.blk_ack[i]);
            c_done[i] += int'(bus.job_done[i]);
            c_err[i]  += int'(bus.job_err[i]);
        end
        bus.eng_done = 1'b0;
        if (eng_cd > 0) begin
            eng_cd--;
            if (eng_cd == 0) bus.eng_done = 1'b1;
        end
        if (bus.eng_go && eng_lat > 0) eng_cd = eng_lat;
        if (vld_auto) begin
            for (int i = 0; i < 2; i++) begin
                if (bus.blk_ack[i] && stage_gap > 0) begin
                    bus.blk_vld[i] = 1'b0;
                    vld_cd[i] = stage_gap;
                end else if (vld_cd[i] > 0) begin
                    vld_cd[i]--;
                    if (vld_cd[i] == 0) bus.blk_vld[i] = 1'b1;
                end
            end
        end
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        bus.req = 2'b00;
        bus.nblk = '0;
        bus.eng_done = 1'b0;
        eng_cd = 0;
        vld_cd[0] = 0; vld_cd[1] = 0;
        bus.blk_vld = vld_auto ? 2'b11 : 2'b00;
        step();
        step();
        rst = 1'b0;
        rr_pref = 0;
    endtask

    // Runs one job from the current request pattern to job_done/job_err plus
    // one following cycle. abort_at >= 0 withdraws the request that many
    // cycles after grant if the job has not completed by then.
    task automatic run_job(input int abort_at, input bit drop_all,
                           output int w, output int wait_n, output bit aborted,
                           output bit gnt_zero, output bit busy_zero, output bit sel_ok);
        int n;
        clr();
        w = 0; wait_n = 0; aborted = 1'b0;
        gnt_zero = 1'b0; busy_zero = 1'b0; sel_ok = 1'b1;
        do begin
            step();
            wait_n++;
        end while (bus.gnt == 2'b00 && wait_n < 50);
        chk("grant_seen", int'(bus.gnt != 2'b00), 1);
        if (bus.gnt == 2'b00) return;
        w = int'(bus.gnt[1]);
        n = 0;
        while (c_done[w] + c_err[w] == 0 && n < 5000) begin
            if (bus.gnt !== 2'(2'b01 << w) || bus.eng_sel !== w[0]) sel_ok = 1'b0;
            if (n == abort_at) begin
                aborted = 1'b1;
                if (drop_all) bus.req = 2'b00; else bus.req[w] = 1'b0;
            end
            step();
            n++;
        end
        chk("job_ended", int'(n < 5000), 1);
        if (drop_all) bus.req = 2'b00; else bus.req[w] = 1'b0;
        step();
        gnt_zero  = (bus.gnt == 2'b00);
        busy_zero = (bus.busy == 1'b0);
    endtask

    initial begin
        #900000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int w, wn, n, blk, w_exp, ab, nbusy;
        bit aborted, gz, bz, sok;
        logic [1:0] pat;

        tbl[0] = '{2'b01,   1, 7, 1, 0, 0,   1};
        tbl[1] = '{2'b10,   2, 3, 1, 0, 1,   3};
        tbl[2] = '{2'b11,   2, 5, 1, 1, 0,   2};
        tbl[3] = '{2'b10,   4, 0, 2, 0, 1,   1};
        tbl[4] = '{2'b01, 255, 1, 1, 0, 0, 255};
        tbl[5] = '{2'b01,   4, 9, 3, 2, 0,   4};

        bus.req = 2'b00; bus.nblk = '0; bus.blk_vld = 2'b00; bus.eng_done = 1'b0;
        reset_dut();
        chk("reset_outputs", outs(), 0);

        // Table vectors: each from a fresh reset, so requester 0 has priority.
        for (int v = 0; v < 6; v++) begin
            vld_auto = 1'b1;
            reset_dut();
            eng_lat = tbl[v].lat;
            stage_gap = tbl[v].gap;
            bus.nblk[0] = NBLK_W'(tbl[v].nb0);
            bus.nblk[1] = NBLK_W'(tbl[v].nb1);
            bus.req = tbl[v].req;
            run_job(-1, 1'b1, w, wn, aborted, gz, bz, sok);
            chk($sformatf("v%0d_winner", v), w, tbl[v].exp_w);
            chk($sformatf("v%0d_init", v), c_init, 1);
            chk($sformatf("v%0d_go", v), c_go, tbl[v].exp_blk);
            chk($sformatf("v%0d_ack", v), c_ack[w], tbl[v].exp_blk);
            chk($sformatf("v%0d_ack_other", v), c_ack[1-w], 0);
            chk($sformatf("v%0d_done", v), c_done[w], 1);
            chk($sformatf("v%0d_err", v), c_err[0] + c_err[1], 0);
            chk($sformatf("v%0d_gnt_after", v), int'(gz), 1);
            chk($sformatf("v%0d_busy_after", v), int'(bz), 1);
            chk($sformatf("v%0d_sel_held", v), int'(sok), 1);
        end
        eng_lat = 1; stage_gap = 0;

        // Minimum block latency: blk_vld raised in LOAD, ack counted in cycles.
        vld_auto = 1'b0;
        reset_dut();
        bus.nblk[0] = NBLK_W'(1);
        bus.req = 2'b01;
        clr();
        n = 0;
        while (c_init == 0 && n < 20) begin step(); n++; end
        step();
        bus.blk_vld[0] = 1'b1;
        n = 0;
        while (c_ack[0] == 0 && n < 20) begin step(); n++; end
        chk("blk_latency", n, 4);
        chk("lat_done_with_ack", c_done[0], 1);
        chk("lat_go_count", c_go, 1);
        bus.req = 2'b00;
        step(); step();
        vld_auto = 1'b1;

        // Arbitration: both request from reset, then both again.
        reset_dut();
        bus.nblk[0] = NBLK_W'(1);
        bus.nblk[1] = NBLK_W'(2);
        bus.req = 2'b11;
        run_job(-1, 1'b0, w, wn, aborted, gz, bz, sok);
        chk("arb1_winner", w, 0);
        chk("arb1_idle_gnt", int'(gz), 1);
        chk("arb1_idle_busy", int'(bz), 1);
        run_job(-1, 1'b0, w, wn, aborted, gz, bz, sok);
        chk("arb2_winner", w, 1);
        chk("arb2_one_idle_cycle", wn, 1);
        chk("arb2_ack", c_ack[1], 2);
        bus.req = 2'b11;
        run_job(-1, 1'b1, w, wn, aborted, gz, bz, sok);
        chk("arb3_winner", w, 0);

        // Abort during WAIT of block 2 of 4.
        reset_dut();
        bus.nblk[0] = NBLK_W'(4);
        bus.req = 2'b01;
        clr();
        n = 0;
        while (c_go < 2 && n < 100) begin step(); n++; end
        chk("abort_reach_wait", c_go, 2);
        bus.req = 2'b00;
        for (int i = 0; i < 4; i++) step();
        chk("abort_err", c_err[0], 1);
        chk("abort_no_done", c_done[0], 0);
        chk("abort_ack", c_ack[0], 1);
        chk("abort_gnt", int'(bus.gnt), 0);
        chk("abort_busy", int'(bus.busy), 0);

        // Engine never answers.
        reset_dut();
        eng_lat = 0;
        bus.nblk[0] = NBLK_W'(1);
        bus.req = 2'b01;
        clr();
        n = 0;
        while (c_go == 0 && n < 50) begin step(); n++; end
`ifdef SCR1_SHA_SCHED_WDOG_EN
        n = 0;
        while (c_err[0] == 0 && n < 200) begin step(); n++; end
        chk("wdog_cycles", n, WDOG);
        chk("wdog_init_pulse", int'(bus.eng_init), 1);
        chk("wdog_gnt", int'(bus.gnt), 0);
        chk("wdog_no_done", c_done[0], 0);
        bus.req = 2'b00;
        step();
        chk("wdog_idle", int'(bus.busy), 0);
`else
        nbusy = 0;
        for (int i = 0; i < 1000; i++) begin
            step();
            nbusy += int'(bus.busy);
        end
        chk("hang_busy", nbusy, 1000);
        chk("hang_no_end", c_err[0] + c_done[0], 0);
`endif
        eng_lat = 1;

        // Reset in WAIT of a 3-block job; requester 0 priority comes back.
        reset_dut();
        bus.nblk[0] = NBLK_W'(3);
        bus.req = 2'b01;
        clr();
        n = 0;
        while (c_go == 0 && n < 50) begin step(); n++; end
        rst = 1'b1;
        step();
        chk("rst_outputs", outs(), 0);
        rst = 1'b0;
        bus.req = 2'b00;
        step();
        chk("rst_release_quiet", pulses(), 0);
        bus.nblk[0] = NBLK_W'(1);
        bus.nblk[1] = NBLK_W'(2);
        bus.req = 2'b11;
        run_job(-1, 1'b0, w, wn, aborted, gz, bz, sok);
        chk("rst_winner0", w, 0);
        run_job(-1, 1'b1, w, wn, aborted, gz, bz, sok);
        chk("rst_winner1", w, 1);
        chk("rst_done1", c_done[1], 1);

        // Random jobs against the job-level model.
        reset_dut();
        for (int j = 0; j < 40; j++) begin
            pat = 2'($urandom_range(1, 3));
            bus.nblk[0] = NBLK_W'($urandom_range(0, 5));
            bus.nblk[1] = NBLK_W'($urandom_range(0, 5));
            eng_lat = $urandom_range(1, 3);
            stage_gap = $urandom_range(0, 2);
            w_exp = pick(pat, rr_pref);
            blk = (bus.nblk[w_exp] == '0) ? 1 : int'(bus.nblk[w_exp]);
            ab = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 4 * blk + 4) : -1;
            bus.req = pat;
            run_job(ab, 1'b1, w, wn, aborted, gz, bz, sok);
            chk($sformatf("r%0d_winner", j), w, w_exp);
            chk($sformatf("r%0d_init", j), c_init, 1);
            chk($sformatf("r%0d_done", j), c_done[w_exp], aborted ? 0 : 1);
            chk($sformatf("r%0d_err", j), c_err[w_exp], aborted ? 1 : 0);
            if (aborted)
                chk($sformatf("r%0d_ack_bound", j), int'(c_ack[w_exp] <= blk), 1);
            else
                chk($sformatf("r%0d_ack", j), c_ack[w_exp], blk);
            chk($sformatf("r%0d_gnt_after", j), int'(gz), 1);
            rr_pref = 1 - w_exp;
            for (int i = 0; i < 5; i++) step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
